serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial add controller that sequences a single full-adder cell over WIDTH-bit operands. It processes one bit per clock, LSB first, and carries between bits in an internal register. Operands arrive and results leave through valid/ready handshakes. The block sits between a requester issuing multi-bit additions and the shared 1-bit adder datapath, trading latency for area.

## Interface
- WIDTH, default 8: operand and result width in bits, must be ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in for the full operation.
- sub  in  1  selects subtract; present only with SERIAL_ADDER_SUB_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- co  out  1  final carry-out.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on in_valid & in_ready. On that edge:
  - latch a and b into shift registers (b_eff = b);
  - set the carry register to ci;
  - clear the bit counter.
- RUN, each cycle:
  - the full-adder cell takes a_sh[0], b_sh[0] and carry;
  - its sum bit shifts into sum_sh at the MSB; a_sh and b_sh shift right;
  - its carry-out updates the carry register;
  - the counter increments.
- RUN → DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1).
- DONE: out_valid=1, sum=sum_sh, co=carry. Both are held stable until out_valid & out_ready.
- DONE → IDLE on out_valid & out_ready. There is no same-edge re-acceptance; in_ready rises the cycle after.
- in_valid outside IDLE is ignored; a/b/ci are sampled only at acceptance.
- Counter width: CNT_W = max(1, $clog2(WIDTH)). For WIDTH=1, RUN lasts exactly one cycle.
- Arithmetic: {co, sum} = a + b_eff + carry_init, modulo 2^(WIDTH+1), with no truncation of co.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, co=0, carry=0, counter=0.
- Latency: out_valid is high in the cycle following the WIDTH-th edge after the acceptance edge.
- Minimum initiation interval: WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE for 1 cycle with out_ready high).
- Back-pressure: while out_ready=0, the block stays in DONE indefinitely and in_ready stays 0.
- rst asserted mid-operation (RUN or DONE):
  - immediate return to reset values;
  - the operation in progress is discarded, with no partial result and no out_valid pulse.
- Combinational outputs (in_ready, out_valid, busy) are decoded from state only. They have no combinational path from in_valid or out_ready.

## Configuration
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - the sub port exists and is sampled at acceptance;
  - sub=1 gives b_eff = ~b with carry_init = 1 (ci ignored), so sum = a − b and co = 1 means no borrow;
  - sub=0 behaves as plain add.
- Undefined: the sub port is absent and the block always adds with carry_init = ci.

## Structure
- Package serial_adder_pkg:
  - state_e enum {IDLE, RUN, DONE};
  - function cnt_w(int width) returning max(1, $clog2(width)).
- One sub-module: instantiates the team's existing full_adder cell as the bit-slice datapath (ports a, b, ci, sum, co).
- The FSM, counter, shift registers and carry register all live in serial_adder_ctrl.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, ci=0 → sum=0x96, co=0; out_valid rises 8 cycles after the acceptance edge.
- a=0xFF, b=0x01, ci=0 → sum=0x00, co=1. Then a=0xFF, b=0xFF, ci=1 → sum=0xFF, co=1.
- Back-pressure:
  - hold out_ready=0 for 5 cycles in DONE → sum/co stable, in_ready=0, in_valid ignored;
  - then out_ready=1 → IDLE, and in_ready=1 the next cycle.
- Reset mid-RUN:
  - assert rst at the 3rd RUN cycle → in_ready=1, out_valid=0, sum=0, co=0 immediately;
  - a fresh a=0x01, b=0x02 → sum=0x03.
- WIDTH=1: a=1, b=1, ci=1 → sum=1, co=1 after 1 RUN cycle.
- With SERIAL_ADDER_SUB_EN:
  - a=0x10, b=0x01, sub=1 → sum=0x0F, co=1;
  - a=0x01, b=0x02, sub=1 → sum=0xFF, co=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used as the shared serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full-adder cell, LSB first, WIDTH cycles per op.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy,
  output state_e           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; ready/valid here depend on state only.

  localparam int                CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic [WIDTH-1:0]   sum_next;
  logic [WIDTH-1:0]   b_eff;
  logic               carry;
  logic               carry_init;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum;
  logic               fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: a + ~b + 1; co=1 means no borrow.
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub ? 1'b1 : ci;
`else
  assign b_eff      = b;
  assign carry_init = ci;
`endif

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_next = fa_sum;
    end else begin : g_wn
      assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= carry_init;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_co;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_sh;
  assign co        = carry;
  assign state_dbg = state;

endmodule
